// File: rtl/spi_reg_ctrl.sv
// rtl/spi_reg_ctrl.sv - SPI frame controller: command/data bytes to register read/write strobes
module spi_reg_ctrl #(
  parameter int ADDR_W   = 6,
  parameter bit AUTO_INC = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cs_n,
  input  logic              byte_sync,
  input  logic [7:0]        data_in,
  output logic [7:0]        data_out,
  output logic [ADDR_W-1:0] reg_addr,
  output logic              reg_wr,
  output logic [7:0]        reg_wdata,
  output logic              reg_rd,
  input  logic [7:0]        reg_rdata,
  output logic              frame_err
);

  typedef enum logic [1:0] {S_CMD, S_RD_REQ, S_RD_LOAD, S_DATA} state_t;

  state_t              state, state_d;
  logic                cs_meta, cs_sync;
  logic                is_wr;
  logic                data_done;
  logic [ADDR_W-1:0]   addr;
  logic [ADDR_W-1:0]   wr_addr;

  always_comb begin
    state_d = state;
    case (state)
      S_CMD:     if (byte_sync) state_d = data_in[7] ? S_DATA : S_RD_REQ;
      S_RD_REQ:  state_d = S_RD_LOAD;
      S_RD_LOAD: state_d = S_DATA;
      S_DATA: begin
        if (byte_sync) begin
          if (AUTO_INC) state_d = is_wr ? S_DATA : S_RD_REQ;
          else          state_d = S_CMD;
        end
      end
      default:   state_d = S_CMD;
    endcase
    if (cs_sync) state_d = S_CMD;
  end

  // addr has already advanced when the write strobe fires, so the strobe uses its own copy
  assign reg_rd   = (state == S_RD_REQ);
  assign reg_addr = reg_wr ? wr_addr : addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_CMD;
      cs_meta   <= 1'b1;
      cs_sync   <= 1'b1;
      is_wr     <= 1'b0;
      data_done <= 1'b0;
      addr      <= '0;
      wr_addr   <= '0;
      data_out  <= 8'h00;
      reg_wr    <= 1'b0;
      reg_wdata <= 8'h00;
      frame_err <= 1'b0;
    end else begin
      cs_meta   <= cs_n;
      cs_sync   <= cs_meta;
      state     <= state_d;
      reg_wr    <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        S_CMD: begin
          if (byte_sync) begin
            is_wr <= data_in[7];
            addr  <= data_in[ADDR_W-1:0];
          end
        end
        S_RD_LOAD: data_out <= reg_rdata;
        S_DATA: begin
          if (byte_sync) begin
            data_done <= 1'b1;
            if (is_wr) begin
              reg_wr    <= 1'b1;
              reg_wdata <= data_in;
              wr_addr   <= addr;
            end
            if (AUTO_INC) addr <= addr + 1'b1;
            else          data_out <= 8'h00;
          end
        end
        default: ;
      endcase
      // A byte completing in the same cycle as CS release still counts as data
      if (cs_sync) begin
        data_out  <= 8'h00;
        data_done <= 1'b0;
        if ((state != S_CMD) && !data_done && !((state == S_DATA) && byte_sync))
          frame_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// tb/tb_spi_reg_ctrl.sv - scoreboard bench for spi_reg_ctrl (AUTO_INC=1 and AUTO_INC=0 instances)
module tb_spi_reg_ctrl;

  localparam int K_MISO = 0;
  localparam int K_WR   = 1;
  localparam int K_RD   = 2;
  localparam int K_ERR  = 3;

  typedef struct {
    int         inst;
    int         kind;
    logic [7:0] a;
    logic [7:0] d;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] cs_n;
  logic [1:0] byte_sync;
  logic [7:0] data_in;
  logic [7:0] data_out  [2];
  logic [5:0] reg_addr  [2];
  logic [1:0] reg_wr;
  logic [7:0] reg_wdata [2];
  logic [1:0] reg_rd;
  logic [7:0] reg_rdata [2];
  logic [1:0] frame_err;

  logic [1:0] miso_valid;
  logic [7:0] miso_byte [2];
  logic [7:0] regfile [64];

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;

  always #5 clk = ~clk;

  spi_reg_ctrl #(.ADDR_W(6), .AUTO_INC(1'b1)) u_dut_inc (
    .clk(clk), .rst_n(rst_n), .cs_n(cs_n[0]), .byte_sync(byte_sync[0]), .data_in(data_in),
    .data_out(data_out[0]), .reg_addr(reg_addr[0]), .reg_wr(reg_wr[0]),
    .reg_wdata(reg_wdata[0]), .reg_rd(reg_rd[0]), .reg_rdata(reg_rdata[0]),
    .frame_err(frame_err[0])
  );

  spi_reg_ctrl #(.ADDR_W(6), .AUTO_INC(1'b0)) u_dut_cmd (
    .clk(clk), .rst_n(rst_n), .cs_n(cs_n[1]), .byte_sync(byte_sync[1]), .data_in(data_in),
    .data_out(data_out[1]), .reg_addr(reg_addr[1]), .reg_wr(reg_wr[1]),
    .reg_wdata(reg_wdata[1]), .reg_rd(reg_rd[1]), .reg_rdata(reg_rdata[1]),
    .frame_err(frame_err[1])
  );

  // Register file model shared by both instances; read data is registered
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 64; i++) regfile[i] <= 8'h00;
      regfile[6'h02] <= 8'hA7;
      regfile[6'h03] <= 8'h6E;
      regfile[6'h10] <= 8'h5A;
      regfile[6'h11] <= 8'hC3;
      regfile[6'h12] <= 8'h0F;
      reg_rdata[0]   <= 8'h00;
      reg_rdata[1]   <= 8'h00;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (reg_wr[k]) regfile[reg_addr[k]] <= reg_wdata[k];
        if (reg_rd[k]) reg_rdata[k] <= regfile[reg_addr[k]];
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_ev(input int inst, input int kind, input logic [7:0] a, input logic [7:0] d);
    ev_t e;
    e.inst = inst; e.kind = kind; e.a = a; e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic check_ev(input int inst, input int kind, input logic [7:0] a, input logic [7:0] d);
    ev_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event: got inst %0d kind %0d a 0x%0h d 0x%0h, expected none",
               inst, kind, a, d);
    end else begin
      e = exp_q.pop_front();
      if (e.inst != inst || e.kind != kind || e.a !== a || e.d !== d) begin
        n_fail++;
        $display("FAIL event: got inst %0d kind %0d a 0x%0h d 0x%0h, expected inst %0d kind %0d a 0x%0h d 0x%0h",
                 inst, kind, a, d, e.inst, e.kind, e.a, e.d);
      end
    end
  endtask

  // Monitor: every observed strobe, error pulse and MISO byte is matched against the queue
  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 2; k++) begin
        if (reg_wr[k] && reg_rd[k]) chk("wr_rd_exclusive", 32'd1, 32'd0);
        if (miso_valid[k]) check_ev(k, K_MISO, 8'h00, miso_byte[k]);
        if (reg_wr[k])     check_ev(k, K_WR, {2'b00, reg_addr[k]}, reg_wdata[k]);
        if (reg_rd[k])     check_ev(k, K_RD, {2'b00, reg_addr[k]}, 8'h00);
        if (frame_err[k])  check_ev(k, K_ERR, 8'h00, 8'h00);
      end
    end
  end

  task automatic check_idle(input int k);
    chk("idle_data_out",  {24'd0, data_out[k]}, 32'd0);
    chk("idle_reg_addr",  {26'd0, reg_addr[k]}, 32'd0);
    chk("idle_reg_wr",    {31'd0, reg_wr[k]}, 32'd0);
    chk("idle_reg_rd",    {31'd0, reg_rd[k]}, 32'd0);
    chk("idle_frame_err", {31'd0, frame_err[k]}, 32'd0);
  endtask

  task automatic frame_start(input int k);
    cs_n[k] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic frame_end(input int k);
    cs_n[k] = 1'b1;
    repeat (6) @(posedge clk);
    #1;
  endtask

  // Bridge model: MISO byte is captured at the start of the transfer, byte_sync at its end
  task automatic xfer(input int k, input logic [7:0] mosi, input bit early_cs);
    repeat (4) @(posedge clk);
    #1;
    miso_byte[k]  = data_out[k];
    miso_valid[k] = 1'b1;
    @(posedge clk);
    #1;
    miso_valid[k] = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    if (early_cs) begin
      cs_n[k] = 1'b1;
      repeat (2) @(posedge clk);
      #1;
    end
    data_in      = mosi;
    byte_sync[k] = 1'b1;
    @(posedge clk);
    #1;
    byte_sync[k] = 1'b0;
  endtask

  initial begin
    rst_n        = 1'b0;
    cs_n         = 2'b11;
    byte_sync    = 2'b00;
    data_in      = 8'h00;
    miso_valid   = 2'b00;
    miso_byte[0] = 8'h00;
    miso_byte[1] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_idle(0);
    check_idle(1);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Write frame
    frame_start(0);
    expect_ev(0, K_MISO, 8'h00, 8'h00); xfer(0, 8'h85, 1'b0);
    expect_ev(0, K_MISO, 8'h00, 8'h00); expect_ev(0, K_WR, 8'h05, 8'h3C); xfer(0, 8'h3C, 1'b0);
    frame_end(0);

    // Read frame; auto-increment prefetches the next address after the dummy
    frame_start(0);
    expect_ev(0, K_MISO, 8'h00, 8'h00); expect_ev(0, K_RD, 8'h02, 8'h00); xfer(0, 8'h02, 1'b0);
    expect_ev(0, K_MISO, 8'h00, 8'hA7); expect_ev(0, K_RD, 8'h03, 8'h00); xfer(0, 8'h00, 1'b0);
    frame_end(0);

    // Burst write wrapping 0x3F -> 0x00
    frame_start(0);
    expect_ev(0, K_MISO, 8'h00, 8'h00); xfer(0, 8'hBF, 1'b0);
    expect_ev(0, K_MISO, 8'h00, 8'h00); expect_ev(0, K_WR, 8'h3F, 8'h11); xfer(0, 8'h11, 1'b0);
    expect_ev(0, K_MISO, 8'h00, 8'h00); expect_ev(0, K_WR, 8'h00, 8'h22); xfer(0, 8'h22, 1'b0);
    frame_end(0);

    // Burst read 0x10..0x12
    frame_start(0);
    expect_ev(0, K_MISO, 8'h00, 8'h00); expect_ev(0, K_RD, 8'h10, 8'h00); xfer(0, 8'h10, 1'b0);
    expect_ev(0, K_MISO, 8'h00, 8'h5A); expect_ev(0, K_RD, 8'h11, 8'h00); xfer(0, 8'h00, 1'b0);
    expect_ev(0, K_MISO, 8'h00, 8'hC3); expect_ev(0, K_RD, 8'h12, 8'h00); xfer(0, 8'h00, 1'b0);
    expect_ev(0, K_MISO, 8'h00, 8'h0F); expect_ev(0, K_RD, 8'h13, 8'h00); xfer(0, 8'h00, 1'b0);
    frame_end(0);

    // Last data byte coincides with CS release: write still fires, no frame error
    frame_start(0);
    expect_ev(0, K_MISO, 8'h00, 8'h00); xfer(0, 8'h87, 1'b0);
    expect_ev(0, K_MISO, 8'h00, 8'h00); expect_ev(0, K_WR, 8'h07, 8'h42); xfer(0, 8'h42, 1'b1);
    frame_end(0);

    // AUTO_INC=0: write then read in one frame
    frame_start(1);
    expect_ev(1, K_MISO, 8'h00, 8'h00); xfer(1, 8'h81, 1'b0);
    expect_ev(1, K_MISO, 8'h00, 8'h00); expect_ev(1, K_WR, 8'h01, 8'h55); xfer(1, 8'h55, 1'b0);
    expect_ev(1, K_MISO, 8'h00, 8'h00); expect_ev(1, K_RD, 8'h03, 8'h00); xfer(1, 8'h03, 1'b0);
    expect_ev(1, K_MISO, 8'h00, 8'h6E); xfer(1, 8'h00, 1'b0);
    frame_end(1);

    // Abort after command, then a normal write
    frame_start(0);
    expect_ev(0, K_MISO, 8'h00, 8'h00); xfer(0, 8'h84, 1'b0);
    repeat (6) @(posedge clk);
    #1;
    expect_ev(0, K_ERR, 8'h00, 8'h00);
    frame_end(0);
    frame_start(0);
    expect_ev(0, K_MISO, 8'h00, 8'h00); xfer(0, 8'h84, 1'b0);
    expect_ev(0, K_MISO, 8'h00, 8'h00); expect_ev(0, K_WR, 8'h04, 8'h99); xfer(0, 8'h99, 1'b0);
    frame_end(0);

    // Reset mid-frame after a write command
    frame_start(0);
    expect_ev(0, K_MISO, 8'h00, 8'h00); xfer(0, 8'h90, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_idle(0);
    cs_n[0] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_idle(0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    frame_start(0);
    expect_ev(0, K_MISO, 8'h00, 8'h00); xfer(0, 8'h90, 1'b0);
    expect_ev(0, K_MISO, 8'h00, 8'h00); expect_ev(0, K_WR, 8'h10, 8'h77); xfer(0, 8'h77, 1'b0);
    frame_end(0);

    repeat (10) @(posedge clk);
    #1;
    chk("pending_events", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
